// File: rtl/in128_out1536_pkg.sv
// Shared constants and types for the 128-to-1536 AXI-Stream upsizer.
// Optional build macro: IN128_OUT1536_KEEP_EN (adds per-lane tkeep on the wide side).
package in128_out1536_pkg;

    localparam int unsigned LANE_W    = 128;
    localparam int unsigned NUM_LANES = 12;
    localparam int unsigned WIDE_W    = LANE_W * NUM_LANES;
    localparam int unsigned CNT_W     = 4;

    // Lane index of the next beat within the word being packed.
    typedef logic [CNT_W-1:0] lane_cnt_t;

    // FILL: accepting narrow beats. HOLD: word complete, waiting for the output slot.
    typedef logic [0:0] state_t;
    localparam state_t ST_FILL = 1'b0;
    localparam state_t ST_HOLD = 1'b1;

endpackage

// File: rtl/in128_out1536_if.sv
// AXI-Stream bundle used on both sides of the upsizer.
//   DATA_W : tdata width.
//   LAST_W : tlast (and tkeep) width; 1 on the narrow side, one bit per lane on the wide side.
// Signals: tdata, tvalid, tready, tlast, and tkeep when IN128_OUT1536_KEEP_EN is defined.
// Modports: master drives the payload, slave drives tready.
interface in128_out1536_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned LAST_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic [LAST_W-1:0] tlast;
`ifdef IN128_OUT1536_KEEP_EN
    logic [LAST_W-1:0] tkeep;

    modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);
`else
    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
`endif
endinterface

// File: rtl/in128_out1536.sv
// Upsizing AXI-Stream converter: packs up to LANES narrow beats into one wide word.
// Beat i of a word lands in lane i; an early tlast flushes a zero-padded partial word.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset.
//   s_axis     : narrow input stream (slave modport), tready registered.
//   m_axis     : wide output stream (master modport); tlast[k] set iff lane k carried tlast.
// Optional build macro: IN128_OUT1536_KEEP_EN adds m_axis.tkeep, a thermometer of filled lanes.
module in128_out1536
    import in128_out1536_pkg::*;
#(
    parameter int unsigned DATA_W = LANE_W,
    parameter int unsigned LANES  = NUM_LANES
) (
    input  logic clk,
    input  logic rst_n,
    in128_out1536_if.slave  s_axis,
    in128_out1536_if.master m_axis
);

    typedef logic [LANES-1:0][DATA_W-1:0] lanes_t;
    typedef logic [LANES-1:0]             lmask_t;

    state_t    state_q, state_d;
    lane_cnt_t cnt_q, cnt_d;
    lanes_t    acc_data_q, acc_data_d;
    lmask_t    acc_last_q, acc_last_d;
    lanes_t    out_data_q, out_data_d;
    lmask_t    out_last_q, out_last_d;
    logic      out_valid_q, out_valid_d;
    logic      s_ready_q, s_ready_d;
`ifdef IN128_OUT1536_KEEP_EN
    lmask_t    out_keep_q, out_keep_d;
`endif

    logic      free_c;
    logic      hs_c;
    logic      complete_c;
    lmask_t    wr_en_c;
    lmask_t    keep_c;
    lanes_t    merged_data_c;
    lmask_t    merged_last_c;
    lanes_t    masked_data_c;
    lmask_t    masked_last_c;

    assign free_c     = ~out_valid_q | m_axis.tready;
    assign hs_c       = s_axis.tvalid & s_ready_q;
    assign complete_c = hs_c & ((cnt_q == lane_cnt_t'(LANES - 1)) | s_axis.tlast[0]);

    // Lane write-enable decode, filled-lane thermometer, and accumulator merged with the incoming beat.
    always_comb begin
        wr_en_c       = '0;
        keep_c        = '0;
        merged_data_c = acc_data_q;
        merged_last_c = acc_last_q;
        masked_data_c = '0;
        masked_last_c = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            wr_en_c[k] = hs_c && (cnt_q == lane_cnt_t'(k));
            keep_c[k]  = (lane_cnt_t'(k) <= cnt_q);
            if (wr_en_c[k]) begin
                merged_data_c[k] = s_axis.tdata;
                merged_last_c[k] = s_axis.tlast[0];
            end
            // Lanes beyond the last written one are forced to zero on flush.
            if (keep_c[k]) begin
                masked_data_c[k] = merged_data_c[k];
                masked_last_c[k] = merged_last_c[k];
            end
        end
    end

    // Next-state and output-register loading.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_data_d  = acc_data_q;
        acc_last_d  = acc_last_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q & ~m_axis.tready;
`ifdef IN128_OUT1536_KEEP_EN
        out_keep_d  = out_keep_q;
`endif

        case (state_q)
            ST_FILL: begin
                if (hs_c) begin
                    acc_data_d = merged_data_c;
                    acc_last_d = merged_last_c;
                    if (complete_c && free_c) begin
                        out_data_d  = masked_data_c;
                        out_last_d  = masked_last_c;
                        out_valid_d = 1'b1;
`ifdef IN128_OUT1536_KEEP_EN
                        out_keep_d  = keep_c;
`endif
                        cnt_d       = '0;
                        acc_data_d  = '0;
                        acc_last_d  = '0;
                    end else if (complete_c) begin
                        // cnt stays on the final lane so the flush mask is still valid in HOLD.
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + lane_cnt_t'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (free_c) begin
                    out_data_d  = masked_data_c;
                    out_last_d  = masked_last_c;
                    out_valid_d = 1'b1;
`ifdef IN128_OUT1536_KEEP_EN
                    out_keep_d  = keep_c;
`endif
                    cnt_d       = '0;
                    acc_data_d  = '0;
                    acc_last_d  = '0;
                    state_d     = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase

        s_ready_d = (state_d == ST_FILL);
    end

    // State and output registers; anything in flight at reset is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            cnt_q       <= '0;
            acc_data_q  <= '0;
            acc_last_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= '0;
            out_valid_q <= 1'b0;
            s_ready_q   <= 1'b0;
`ifdef IN128_OUT1536_KEEP_EN
            out_keep_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_data_q  <= acc_data_d;
            acc_last_q  <= acc_last_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            s_ready_q   <= s_ready_d;
`ifdef IN128_OUT1536_KEEP_EN
            out_keep_q  <= out_keep_d;
`endif
        end
    end

    assign s_axis.tready = s_ready_q;
    assign m_axis.tdata  = out_data_q;
    assign m_axis.tlast  = out_last_q;
    assign m_axis.tvalid = out_valid_q;
`ifdef IN128_OUT1536_KEEP_EN
    assign m_axis.tkeep  = out_keep_q;
`endif

endmodule
